// File: rtl/cdb_arbiter.sv
// cdb_arbiter: RS and LSB result FIFOs sharing one registered CDB through a round-robin arbiter.
// Define CDB_ARB_LSB_PRIORITY_EN to make the LSB win every contention instead.
module cdb_arbiter #(
  parameter int DEST_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  reset_from_rob_bus,
  input  logic [DEST_WIDTH-1:0] dest_from_rs,
  input  logic [DATA_WIDTH-1:0] value_from_rs,
  input  logic [DATA_WIDTH-1:0] next_pc_from_rs,
  input  logic [DEST_WIDTH-1:0] dest_from_lsb,
  input  logic [DATA_WIDTH-1:0] value_from_lsb,
  output logic                  is_rs_fifo_full,
  output logic                  is_lsb_fifo_full,
  output logic [DEST_WIDTH-1:0] dest_to_cdb,
  output logic [DATA_WIDTH-1:0] value_to_cdb,
  output logic [DATA_WIDTH-1:0] next_pc_to_cdb,
  output logic                  src_to_cdb
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  logic [DEST_WIDTH-1:0] rs_dest [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs_value [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs_pc [FIFO_DEPTH];
  logic [DEST_WIDTH-1:0] lsb_dest [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] lsb_value [FIFO_DEPTH];
  logic [AW-1:0] rs_wp, rs_rp, lsb_wp, lsb_rp;
  logic [AW:0] rs_cnt, lsb_cnt;
  logic flush, go, rs_ne, lsb_ne, push_rs, push_lsb, pop_rs, pop_lsb;
  assign flush = rst || reset_from_rob_bus;
  assign go = rdy && !flush;
  assign rs_ne = rs_cnt != '0;
  assign lsb_ne = lsb_cnt != '0;
  assign is_rs_fifo_full = rs_cnt == DEPTH;
  assign is_lsb_fifo_full = lsb_cnt == DEPTH;
  // a full FIFO refuses the push even if it is popped on the same edge
  assign push_rs = go && |dest_from_rs && !is_rs_fifo_full;
  assign push_lsb = go && |dest_from_lsb && !is_lsb_fifo_full;
`ifdef CDB_ARB_LSB_PRIORITY_EN
  assign pop_lsb = go && lsb_ne;
  assign pop_rs = go && rs_ne && !lsb_ne;
`else
  logic last_grant;
  assign pop_rs = go && rs_ne && (!lsb_ne || last_grant);
  assign pop_lsb = go && lsb_ne && !pop_rs;
`endif
  always_ff @(posedge clk) begin
    if (push_rs) begin
      rs_dest[rs_wp] <= dest_from_rs;
      rs_value[rs_wp] <= value_from_rs;
      rs_pc[rs_wp] <= next_pc_from_rs;
    end
    if (push_lsb) begin
      lsb_dest[lsb_wp] <= dest_from_lsb;
      lsb_value[lsb_wp] <= value_from_lsb;
    end
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      rs_wp <= '0;
      rs_rp <= '0;
      rs_cnt <= '0;
      lsb_wp <= '0;
      lsb_rp <= '0;
      lsb_cnt <= '0;
`ifndef CDB_ARB_LSB_PRIORITY_EN
      last_grant <= 1'b1;
`endif
      dest_to_cdb <= '0;
      value_to_cdb <= '0;
      next_pc_to_cdb <= '0;
      src_to_cdb <= 1'b0;
    end else if (rdy) begin
      if (push_rs) rs_wp <= rs_wp + AW'(1);
      if (pop_rs) rs_rp <= rs_rp + AW'(1);
      if (push_lsb) lsb_wp <= lsb_wp + AW'(1);
      if (pop_lsb) lsb_rp <= lsb_rp + AW'(1);
      rs_cnt <= rs_cnt + (AW+1)'(push_rs) - (AW+1)'(pop_rs);
      lsb_cnt <= lsb_cnt + (AW+1)'(push_lsb) - (AW+1)'(pop_lsb);
`ifndef CDB_ARB_LSB_PRIORITY_EN
      if (rs_ne && lsb_ne) last_grant <= pop_lsb;
`endif
      dest_to_cdb <= pop_rs ? rs_dest[rs_rp] : pop_lsb ? lsb_dest[lsb_rp] : '0;
      value_to_cdb <= pop_rs ? rs_value[rs_rp] : pop_lsb ? lsb_value[lsb_rp] : '0;
      next_pc_to_cdb <= pop_rs ? rs_pc[rs_rp] : '0;
      src_to_cdb <= pop_lsb;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter; honours CDB_ARB_LSB_PRIORITY_EN.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic reset_from_rob_bus = 1'b0;
  logic [4:0] dest_from_rs = '0;
  logic [31:0] value_from_rs = '0;
  logic [31:0] next_pc_from_rs = '0;
  logic [4:0] dest_from_lsb = '0;
  logic [31:0] value_from_lsb = '0;
  logic is_rs_fifo_full, is_lsb_fifo_full;
  logic [4:0] dest_to_cdb;
  logic [31:0] value_to_cdb, next_pc_to_cdb;
  logic src_to_cdb;
  int checks = 0;
  int errors = 0;
  logic [68:0] rs_q[$];
  logic [68:0] lsb_q[$];
  logic [4:0] obs_q[$];
  logic [69:0] held = '0;
  bit seen7 = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_from_rs(dest_from_rs), .value_from_rs(value_from_rs), .next_pc_from_rs(next_pc_from_rs),
    .dest_from_lsb(dest_from_lsb), .value_from_lsb(value_from_lsb),
    .is_rs_fifo_full(is_rs_fifo_full), .is_lsb_fifo_full(is_lsb_fifo_full),
    .dest_to_cdb(dest_to_cdb), .value_to_cdb(value_to_cdb),
    .next_pc_to_cdb(next_pc_to_cdb), .src_to_cdb(src_to_cdb)
  );

  always #5 clk = ~clk;

`ifdef CDB_ARB_LSB_PRIORITY_EN
  localparam int T4_RS = 4;
  localparam int T4_LSB = 4;
`else
  localparam int T4_RS = 7;
  localparam int T4_LSB = 6;
`endif

  function automatic logic [69:0] bus_now();
    return {dest_to_cdb, value_to_cdb, next_pc_to_cdb, src_to_cdb};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; the broadcast made at this edge is matched against its source queue
  task automatic tick();
    logic was_rdy, was_flush;
    logic [68:0] e;
    was_rdy = rdy;
    was_flush = rst | reset_from_rob_bus;
    @(posedge clk);
    #1;
    if (was_flush) begin
      chk("flush_bus", bus_now(), '0);
      chk("flush_full", {is_rs_fifo_full, is_lsb_fifo_full}, '0);
    end else if (!was_rdy) begin
      chk("stall_hold", bus_now(), held);
    end else if (dest_to_cdb != '0) begin
      obs_q.push_back(dest_to_cdb);
      if (dest_to_cdb == 5'd7) seen7 = 1;
      if (src_to_cdb ? lsb_q.size() == 0 : rs_q.size() == 0) chk("unexpected_bcast", bus_now(), '0);
      else begin
        e = src_to_cdb ? lsb_q.pop_front() : rs_q.pop_front();
        chk(src_to_cdb ? "lsb_bcast" : "rs_bcast", {dest_to_cdb, value_to_cdb, next_pc_to_cdb}, e);
      end
    end
    held = bus_now();
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] rv, input logic [31:0] rn,
                       input logic [4:0] ld, input logic [31:0] lv, input bit accept);
    dest_from_rs = rd;
    value_from_rs = rv;
    next_pc_from_rs = rn;
    dest_from_lsb = ld;
    value_from_lsb = lv;
    if (accept && rd != '0) rs_q.push_back({rd, rv, rn});
    if (accept && ld != '0) lsb_q.push_back({ld, lv, 32'h0});
    tick();
    dest_from_rs = '0;
    dest_from_lsb = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs_q.delete();
    lsb_q.delete();
    obs_q.delete();
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) tick();
    chk({tag, "_rs_left"}, rs_q.size(), 0);
    chk({tag, "_lsb_left"}, lsb_q.size(), 0);
  endtask

  initial begin
    logic [4:0] ord2[2];
    logic [4:0] ord3[8];
`ifdef CDB_ARB_LSB_PRIORITY_EN
    ord2 = '{5'd5, 5'd2};
    ord3 = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd1, 5'd2, 5'd3, 5'd4};
`else
    ord2 = '{5'd2, 5'd5};
    ord3 = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
`endif
    tick();
    do_reset();
    chk("reset_bus", bus_now(), '0);
    chk("reset_full", {is_rs_fifo_full, is_lsb_fifo_full}, '0);

    // single RS push: two edges to the bus, one cycle visible
    drive(5'd3, 32'h11, 32'h104, 5'd0, 32'h0, 1);
    chk("t1_no_bypass", dest_to_cdb, 5'd0);
    tick();
    chk("t1_latency", {dest_to_cdb, src_to_cdb, 32'(rs_q.size())}, {5'd3, 1'b0, 32'd0});
    tick();
    chk("t1_idle", dest_to_cdb, 5'd0);

    do_reset();
    drive(5'd2, 32'h22, 32'h208, 5'd5, 32'h55, 1);
    drain(4, "t2");
    chk("t2_count", obs_q.size(), 2);
    for (int i = 0; i < 2 && i < obs_q.size(); i++) chk("t2_order", obs_q[i], ord2[i]);

    do_reset();
    for (int i = 0; i < 4; i++)
      drive(5'(1 + i), 32'h100 + 32'(i), 32'h400 + 32'(4 * i), 5'(9 + i), 32'h900 + 32'(i), 1);
    drain(10, "t3");
    chk("t3_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("t3_order", obs_q[i], ord3[i]);

    // fill RS under contention, stall, then push while full
    do_reset();
    seen7 = 0;
    for (int i = 0; i < T4_RS; i++)
      drive(5'(20 + i), 32'h2000 + 32'(i), 32'h800 + 32'(4 * i),
            i < T4_LSB ? 5'(9 + i) : 5'd0, 32'h3000 + 32'(i), 1);
    rdy = 1'b0;
    tick();
    tick();
    chk("t4_rs_full", is_rs_fifo_full, 1'b1);
    rdy = 1'b1;
    drive(5'd7, 32'h77, 32'h7700, 5'd0, 32'h0, 0);
    drain(16, "t4");
    chk("t4_dropped", seen7, 1'b0);

    // mispredict flush with entries queued and a push on the flush edge
    do_reset();
    drive(5'd1, 32'h1, 32'h10, 5'd9, 32'h9, 1);
    drive(5'd2, 32'h2, 32'h20, 5'd10, 32'h10, 1);
    reset_from_rob_bus = 1'b1;
    dest_from_rs = 5'd15;
    tick();
    reset_from_rob_bus = 1'b0;
    dest_from_rs = '0;
    rs_q.delete();
    lsb_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_stale", dest_to_cdb, 5'd0);
    end

    // stall while a broadcast is on the bus
    do_reset();
    drive(5'd6, 32'h66, 32'h600, 5'd0, 32'h0, 1);
    drive(5'd8, 32'h88, 32'h800, 5'd0, 32'h0, 1);
    chk("t6_on_bus", dest_to_cdb, 5'd6);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold", dest_to_cdb, 5'd6);
    end
    rdy = 1'b1;
    tick();
    chk("t6_next", dest_to_cdb, 5'd8);
    tick();
    chk("t6_idle", dest_to_cdb, 5'd0);
    drain(2, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
